instr_dispatch: RTL and testbench

INSTR_DISPATCH -- requirements
Module: instr_dispatch

---
 rtl/instr_dispatch.sv | 172 +++++++++++++++++
 tb/tb_instr_dispatch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_dispatch.sv
// Instruction dispatcher: buffers fetched instructions, decodes opcodes and issues them one at a time
// to four execution units. Optional perf counters are enabled with macro DISPATCH_PERF_CNT_EN.
module instr_dispatch #(
  parameter int FIFO_DEPTH   = 16,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        o_fetch_enable,
  input  logic [63:0] i_instr,
  input  logic        i_instr_enable,
  output logic [3:0]  o_unit_req,
  output logic [63:0] o_unit_instr,
  input  logic [3:0]  i_unit_done,
  output logic        o_busy,
  output logic        o_run_done,
  output logic [2:0]  o_err
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0] o_issue_cnt,
  output logic [31:0] o_stall_cnt
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(DONE_TIMEOUT + 2);
  localparam logic [TW-1:0] TMO_LAST = TW'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [63:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      req_q, req_d;
  logic [63:0]     instr_q, instr_d;
  logic [2:0]      err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            fetch_q, fetch_d;

  logic [63:0] head;
  logic [7:0]  opcode;
  logic [3:0]  head_unit;
  logic        start_ok, pop, full, wr, ovf, flush, done_hit, tmo_hit, issue;

  assign head   = mem_q[rd_ptr_q];
  assign opcode = head[63:56];

  always_comb begin
    head_unit = 4'b0000;
    case (opcode)
      8'h01:   head_unit = 4'b0001;
      8'h02:   head_unit = 4'b0010;
      8'h03:   head_unit = 4'b0100;
      8'h04:   head_unit = 4'b1000;
      default: head_unit = 4'b0000;
    endcase
  end

  assign start_ok = (state_q == S_IDLE) && start;
  assign pop      = (state_q == S_DECODE) && (count_q != '0);
  assign flush    = pop && (opcode == 8'hFF);
  assign issue    = pop && (head_unit != 4'b0000);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  // A pop frees a slot in the same cycle, so a write against a full FIFO still lands.
  assign wr       = i_instr_enable && (!full || pop) && !flush;
  assign ovf      = i_instr_enable && full && !pop;
  assign done_hit = (state_q == S_ISSUE) && ((i_unit_done & req_q) != 4'b0000);
  assign tmo_hit  = (DONE_TIMEOUT > 0) && (state_q == S_ISSUE) && !done_hit && (tmo_q == TMO_LAST);

  always_comb begin
    wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr) - CW'(pop);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    instr_d = instr_q;
    tmo_d   = '0;
    err_d   = start_ok ? 3'b000 : err_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (count_q != '0) state_d = S_DECODE;
      S_DECODE: begin
        if (count_q == '0) begin
          state_d = S_FETCH;
        end else if (opcode == 8'hFF) begin
          state_d = S_DONE;
        end else if (head_unit != 4'b0000) begin
          req_d   = head_unit;
          instr_d = head;
          state_d = S_ISSUE;
        end else begin
          if (opcode != 8'h00) err_d[1] = 1'b1;
          if (count_d == '0) state_d = S_FETCH;
        end
      end
      S_ISSUE: begin
        if (done_hit || tmo_hit) begin
          req_d = 4'b0000;
          if (tmo_hit) err_d[2] = 1'b1;
          state_d = (count_q != '0) ? S_DECODE : S_FETCH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ovf) err_d[0] = 1'b1;
    fetch_d = (state_d == S_FETCH) && (state_q != S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      req_q    <= 4'b0000;
      instr_q  <= '0;
      err_q    <= 3'b000;
      tmo_q    <= '0;
      fetch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      req_q    <= req_d;
      instr_q  <= instr_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      fetch_q  <= fetch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= i_instr;
  end

  assign o_fetch_enable = fetch_q;
  assign o_unit_req     = req_q;
  assign o_unit_instr   = instr_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_run_done     = (state_q == S_DONE);
  assign o_err          = err_q;

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue && (issue_cnt_q != '1)) issue_cnt_q <= issue_cnt_q + 32'd1;
      if ((state_q == S_ISSUE) && !done_hit && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
  assign o_issue_cnt = issue_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed self-checking bench for instr_dispatch (FIFO_DEPTH=16, DONE_TIMEOUT=8).
module tb_instr_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        o_fetch_enable;
  logic [63:0] i_instr = '0;
  logic        i_instr_enable = 1'b0;
  logic [3:0]  o_unit_req;
  logic [63:0] o_unit_instr;
  logic [3:0]  i_unit_done = 4'b0000;
  logic        o_busy, o_run_done;
  logic [2:0]  o_err;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] o_issue_cnt, o_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int run_done_cnt = 0;
  logic [3:0] issued [$];
  logic [3:0] prev_req = 4'b0000;

  instr_dispatch #(.FIFO_DEPTH(16), .DONE_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .o_fetch_enable(o_fetch_enable),
    .i_instr(i_instr), .i_instr_enable(i_instr_enable), .o_unit_req(o_unit_req),
    .o_unit_instr(o_unit_instr), .i_unit_done(i_unit_done), .o_busy(o_busy),
    .o_run_done(o_run_done), .o_err(o_err)
`ifdef DISPATCH_PERF_CNT_EN
    , .o_issue_cnt(o_issue_cnt), .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Observe issue order and run-done pulses away from the active edge.
  always @(negedge clk) begin
    if (o_run_done) run_done_cnt++;
    if (o_unit_req != 4'b0000 && prev_req == 4'b0000) issued.push_back(o_unit_req);
    prev_req = o_unit_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] w);
    i_instr = w;
    i_instr_enable = 1'b1;
    tick();
    i_instr_enable = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (o_unit_req == 4'b0000 && n < 60) begin
      tick();
      n++;
    end
    chk("wait_req", 64'(o_unit_req != 4'b0000), 64'd1);
  endtask

  // Requested done lands in the third request cycle; a stray done for other units comes first.
  task automatic serve(input string tag, input logic [3:0] exp_req, input logic [63:0] exp_instr);
    wait_req();
    chk({tag, "_req"}, 64'(o_unit_req), 64'(exp_req));
    chk({tag, "_instr"}, o_unit_instr, exp_instr);
    tick();
    i_unit_done = ~exp_req;
    tick();
    chk({tag, "_hold"}, 64'(o_unit_req), 64'(exp_req));
    i_unit_done = exp_req;
    tick();
    i_unit_done = 4'b0000;
    chk({tag, "_drop"}, 64'(o_unit_req), 64'd0);
  endtask

  initial begin
    logic [63:0] w_lf, w_lw, w_cv, w_st, w_end, w_nop, w;
    int n;
    w_lf  = {8'h04, 56'h11};
    w_lw  = {8'h01, 56'h22};
    w_cv  = {8'h02, 56'h33};
    w_st  = {8'h03, 56'h44};
    w_end = {8'hFF, 56'h0};
    w_nop = {8'h00, 56'h0};

    tick();
    tick();
    rst = 1'b0;
    chk("rst_req", 64'(o_unit_req), 64'd0);
    chk("rst_instr", o_unit_instr, 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_fetch", 64'(o_fetch_enable), 64'd0);
    chk("rst_done", 64'(o_run_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);

    // Basic program: load-feature, load-weight, conv, store, END.
    push(w_lf); push(w_lw); push(w_cv); push(w_st); push(w_end);
    pulse_start();
    chk("t1_fetch_pulse", 64'(o_fetch_enable), 64'd1);
    chk("t1_busy", 64'(o_busy), 64'd1);
    tick();
    chk("t1_fetch_once", 64'(o_fetch_enable), 64'd0);
    serve("t1_lf", 4'b1000, w_lf);
    serve("t1_lw", 4'b0001, w_lw);
    serve("t1_cv", 4'b0010, w_cv);
    serve("t1_st", 4'b0100, w_st);
    repeat (4) tick();
    chk("t1_run_done", 64'(run_done_cnt), 64'd1);
    chk("t1_err", 64'(o_err), 64'd0);
    chk("t1_idle", 64'(o_busy), 64'd0);
    chk("t1_n_issued", 64'(issued.size()), 64'd4);
    if (issued.size() == 4)
      chk("t1_order", 64'({issued[0], issued[1], issued[2], issued[3]}), 64'h8124);
`ifdef DISPATCH_PERF_CNT_EN
    chk("t1_issue_cnt", 64'(o_issue_cnt), 64'd4);
    chk("t1_stall_cnt", 64'(o_stall_cnt), 64'd8);
`endif

    // Overflow: 17 back-to-back writes into an idle 16-entry FIFO.
    issued.delete();
    i_instr_enable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      w = (i < 14) ? w_nop : (i == 14) ? {8'h03, 56'hA} : (i == 15) ? {8'h02, 56'hB} : {8'h04, 56'hC};
      i_instr = w;
      tick();
      if (i == 15) chk("t2_full_no_err", 64'(o_err), 64'd0);
    end
    i_instr_enable = 1'b0;
    chk("t2_ovf_err", 64'(o_err), 64'd1);
    pulse_start();
    chk("t2_err_cleared", 64'(o_err), 64'd0);
    serve("t2_st", 4'b0100, {8'h03, 56'hA});
    serve("t2_cv", 4'b0010, {8'h02, 56'hB});
    chk("t2_refetch", 64'(o_fetch_enable), 64'd1);
    repeat (3) tick();
    chk("t2_no_17th", 64'(issued.size()), 64'd2);
    push(w_end);
    repeat (5) tick();
    chk("t2_run_done", 64'(run_done_cnt), 64'd2);

    // Illegal opcode, NOP, END.
    issued.delete();
    push({8'h07, 56'h5}); push(w_nop); push(w_end);
    pulse_start();
    repeat (8) tick();
    chk("t3_err", 64'(o_err), 64'd2);
    chk("t3_no_req", 64'(issued.size()), 64'd0);
    chk("t3_run_done", 64'(run_done_cnt), 64'd3);
    chk("t3_idle", 64'(o_busy), 64'd0);

    // Done timeout after 8 request cycles, then the next instruction still issues.
    issued.delete();
    push({8'h01, 56'hD}); push({8'h02, 56'hE});
    pulse_start();
    wait_req();
    chk("t4_req", 64'(o_unit_req), 64'd1);
    n = 0;
    while (o_unit_req != 4'b0000 && n < 30) begin
      tick();
      n++;
    end
    chk("t4_req_cycles", 64'(n), 64'd8);
    chk("t4_err", 64'(o_err), 64'd4);
    serve("t4_cv", 4'b0010, {8'h02, 56'hE});
    push(w_end);
    repeat (5) tick();
    chk("t4_run_done", 64'(run_done_cnt), 64'd4);

    // Reset while a conv request is outstanding; late done is ignored.
    push({8'h02, 56'hF});
    pulse_start();
    wait_req();
    chk("t5_req", 64'(o_unit_req), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_req0", 64'(o_unit_req), 64'd0);
    chk("t5_instr0", o_unit_instr, 64'd0);
    chk("t5_busy0", 64'(o_busy), 64'd0);
    chk("t5_fetch0", 64'(o_fetch_enable), 64'd0);
    chk("t5_done0", 64'(o_run_done), 64'd0);
    chk("t5_err0", 64'(o_err), 64'd0);
    i_unit_done = 4'b0010;
    tick();
    i_unit_done = 4'b0000;
    tick();
    chk("t5_late_req", 64'(o_unit_req), 64'd0);
    chk("t5_late_busy", 64'(o_busy), 64'd0);
    pulse_start();
    repeat (3) tick();
    chk("t5_empty_wait", 64'({o_busy, o_unit_req}), 64'h10);
    push(w_end);
    repeat (5) tick();
    chk("t5_run_done", 64'(run_done_cnt), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
